// File: rtl/flash_pkg.sv
// Shared definitions for the flash-to-RAM loader: state encoding, flash
// address width and the default flash_ready timeout.
package flash_pkg;

  localparam int FL_AW                  = 22;
  localparam int TIMEOUT_CYCLES_DEFAULT = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } state_e;

  // Flash word address of the n-th word of a copy; wraps modulo 2^FL_AW.
  function automatic logic [FL_AW-1:0] fl_word_addr(input logic [FL_AW-1:0] base,
                                                    input logic [15:0]      offset);
    return base + FL_AW'(offset);
  endfunction

endpackage

// File: rtl/flash_loader_if.sv
// Flash-controller and RAM write buses driven by the loader (master) and
// served by the surrounding system (slave).
interface flash_loader_if #(
  parameter int RAM_AW = 18
);
  import flash_pkg::*;

  logic [FL_AW-1:0]  fl_addr;
  logic              fl_read_ctrl;
  logic [15:0]       fl_data;
  logic              fl_ready;

  logic [RAM_AW-1:0] ram_addr;
  logic [15:0]       ram_wdata;
  logic              ram_we;
  logic              ram_ack;

  modport master (
    output fl_addr, fl_read_ctrl,
    input  fl_data, fl_ready,
    output ram_addr, ram_wdata, ram_we,
    input  ram_ack
  );

  modport slave (
    input  fl_addr, fl_read_ctrl,
    output fl_data, fl_ready,
    input  ram_addr, ram_wdata, ram_we,
    output ram_ack
  );

endinterface

// File: rtl/flash_wd_timer.sv
// Watchdog for one flash_ready wait phase: clear on entry, count while the
// awaited level is absent, flag expiry on the last permitted cycle.
module flash_wd_timer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of the order in which blocks evaluate.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/flash_loader.sv
// Copies word_count 16-bit words from the toggle-handshake flash controller
// into RAM, one read/write pair at a time, with a timeout on each flash wait.
module flash_loader
  import flash_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int RAM_AW         = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FL_AW-1:0]  src_base,
  input  logic [RAM_AW-1:0] dst_base,
  input  logic [15:0]       word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_done,
  flash_loader_if.master    bus
);

  state_e            state_q;
  logic [FL_AW-1:0]  src_q;
  logic [RAM_AW-1:0] dst_q;
  logic [15:0]       count_q;
  logic [15:0]       words_done_q;
  logic [FL_AW-1:0]  fl_addr_q;
  logic              fl_read_ctrl_q;
  logic [RAM_AW-1:0] ram_addr_q;
  logic [15:0]       ram_wdata_q;
  logic              ram_we_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;

  logic              wd_clr;
  logic              wd_en;
  logic              wd_expired;
  logic [15:0]       words_inc;

  assign words_inc = words_done_q + 16'd1;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    wd_clr = 1'b1;
    wd_en  = 1'b0;
    case (state_q)
      ST_WAIT_LOW: begin
        wd_clr = !bus.fl_ready;
        wd_en  = bus.fl_ready;
      end
      ST_WAIT_HIGH: begin
        wd_clr = 1'b0;
        wd_en  = !bus.fl_ready;
      end
      default: ;
    endcase
  end

  flash_wd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expired_o(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      src_q          <= '0;
      dst_q          <= '0;
      count_q        <= '0;
      words_done_q   <= '0;
      fl_addr_q      <= '0;
      fl_read_ctrl_q <= 1'b0;
      ram_addr_q     <= '0;
      ram_wdata_q    <= '0;
      ram_we_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            src_q        <= src_base;
            dst_q        <= dst_base;
            count_q      <= word_count;
            words_done_q <= '0;
            error_q      <= 1'b0;
            if (word_count == 16'd0) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_ISSUE;
              busy_q    <= 1'b1;
              done_q    <= 1'b0;
              // Address is presented during ISSUE, ahead of the toggle edge.
              fl_addr_q <= src_base;
            end
          end
        end

        ST_ISSUE: begin
          fl_read_ctrl_q <= ~fl_read_ctrl_q;
          state_q        <= ST_WAIT_LOW;
        end

        ST_WAIT_LOW: begin
          if (!bus.fl_ready) begin
            state_q <= ST_WAIT_HIGH;
          end else if (wd_expired) begin
            state_q <= ST_ERR;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end
        end

        ST_WAIT_HIGH: begin
          if (bus.fl_ready) begin
            ram_wdata_q <= bus.fl_data;
            ram_addr_q  <= dst_q + RAM_AW'(words_done_q);
            ram_we_q    <= 1'b1;
            state_q     <= ST_WRITE;
          end else if (wd_expired) begin
            state_q <= ST_ERR;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end
        end

        ST_WRITE: begin
          if (bus.ram_ack) begin
            ram_we_q     <= 1'b0;
            words_done_q <= words_inc;
            if (words_inc == count_q) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_ISSUE;
              fl_addr_q <= fl_word_addr(src_q, words_inc);
            end
          end
        end

        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          ram_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fl_addr      = fl_addr_q;
  assign bus.fl_read_ctrl = fl_read_ctrl_q;
  assign bus.ram_addr     = ram_addr_q;
  assign bus.ram_wdata    = ram_wdata_q;
  assign bus.ram_we       = ram_we_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign words_done       = words_done_q;

endmodule

// File: tb/tb_flash_loader.sv
// Self-checking bench for flash_loader: behavioural flash controller and RAM
// models, randomized timing, expectations from copy arithmetic.
module tb_flash_loader;
  import flash_pkg::*;

  localparam int RAM_AW = 18;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [FL_AW-1:0]  src_base = '0;
  logic [RAM_AW-1:0] dst_base = '0;
  logic [15:0]       word_count = '0;
  logic              busy;
  logic              done;
  logic              error;
  logic [15:0]       words_done;

  int errors = 0;
  int checks = 0;

  flash_loader_if #(.RAM_AW(RAM_AW)) bus ();

  flash_loader #(
    .TIMEOUT_CYCLES(TMO),
    .RAM_AW        (RAM_AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .src_base  (src_base),
    .dst_base  (dst_base),
    .word_count(word_count),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .words_done(words_done),
    .bus       (bus)
  );

  initial forever #5 clk = ~clk;

  // Flash contents: a fixed scramble of the word address.
  function automatic logic [15:0] fl_word(input logic [FL_AW-1:0] a);
    return a[15:0] ^ {a[21:16], a[21:12]} ^ 16'hA5C3;
  endfunction

  // ---------------- flash controller model ----------------
  bit               fl_stuck = 1'b0;
  int               toggles = 0;
  int               fl_addr_unstable = 0;
  logic [FL_AW-1:0] fl_addr_log[$];

  initial begin : flash_model
    logic             last_ctrl;
    int               phase;
    int               cnt;
    logic [FL_AW-1:0] a;
    bus.fl_ready = 1'b1;
    bus.fl_data  = '0;
    last_ctrl    = 1'b0;
    phase        = 0;
    cnt          = 0;
    a            = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        last_ctrl    = 1'b0;
        phase        = 0;
        bus.fl_ready = 1'b1;
      end else begin
        if ((phase == 1 || phase == 2) && bus.fl_addr !== a) fl_addr_unstable++;
        if (bus.fl_read_ctrl !== last_ctrl) begin
          last_ctrl = bus.fl_read_ctrl;
          toggles++;
          a = bus.fl_addr;
          fl_addr_log.push_back(a);
          phase = fl_stuck ? 3 : 1;
          cnt   = $urandom_range(3, 1);
        end else if (phase == 1) begin
          cnt--;
          if (cnt == 0) begin
            bus.fl_ready = 1'b0;
            phase        = 2;
            cnt          = $urandom_range(5, 2);
          end
        end else if (phase == 2) begin
          cnt--;
          if (cnt == 0) begin
            bus.fl_ready = 1'b1;
            bus.fl_data  = fl_word(a);
            phase        = 0;
          end
        end
      end
    end
  end

  // ---------------- RAM model ----------------
  int                ack_plan[$];
  logic [RAM_AW-1:0] wr_addr_log[$];
  logic [15:0]       wr_data_log[$];
  int                wr_cycles_log[$];
  int                ram_unstable = 0;
  int                we_cycles_total = 0;

  initial begin : ram_model
    int                need;
    int                seen;
    bit                active;
    logic [RAM_AW-1:0] wa;
    logic [15:0]       wd;
    bus.ram_ack = 1'b0;
    active      = 1'b0;
    need        = 1;
    seen        = 0;
    wa          = '0;
    wd          = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        bus.ram_ack = 1'b0;
        active      = 1'b0;
      end else if (bus.ram_ack) begin
        bus.ram_ack = 1'b0;
        active      = 1'b0;
      end else if (bus.ram_we) begin
        we_cycles_total++;
        if (!active) begin
          active = 1'b1;
          seen   = 0;
          wa     = bus.ram_addr;
          wd     = bus.ram_wdata;
          need   = (ack_plan.size() > 0) ? ack_plan.pop_front() : 1;
        end else if (bus.ram_addr !== wa || bus.ram_wdata !== wd) begin
          ram_unstable++;
        end
        seen++;
        if (seen >= need) begin
          bus.ram_ack = 1'b1;
          wr_addr_log.push_back(wa);
          wr_data_log.push_back(wd);
          wr_cycles_log.push_back(seen);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_logs();
    toggles          = 0;
    fl_addr_unstable = 0;
    ram_unstable     = 0;
    we_cycles_total  = 0;
    fl_addr_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    wr_cycles_log.delete();
    ack_plan.delete();
  endtask

  task automatic pulse_start(input logic [FL_AW-1:0] s, input logic [RAM_AW-1:0] d,
                             input logic [15:0] n);
    src_base   = s;
    dst_base   = d;
    word_count = n;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy === 1'b1 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: still busy after %0d cycles, required idle", tag, budget);
    end
  endtask

  // Compare the finished copy against the copy arithmetic for (s, d, n).
  task automatic verify_copy(input string tag, input logic [FL_AW-1:0] s,
                             input logic [RAM_AW-1:0] d, input int n);
    logic [FL_AW-1:0]  ef;
    logic [RAM_AW-1:0] ea;
    checks += 7;
    if (done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b required 1", tag, done); end
    if (error !== 1'b0) begin errors++; $display("FAIL %s_error: got %b required 0", tag, error); end
    if (words_done !== 16'(n)) begin
      errors++; $display("FAIL %s_words_done: got %0d required %0d", tag, words_done, n);
    end
    if (toggles != n) begin errors++; $display("FAIL %s_toggles: got %0d required %0d", tag, toggles, n); end
    if (wr_addr_log.size() != n) begin
      errors++; $display("FAIL %s_writes: got %0d required %0d", tag, wr_addr_log.size(), n);
    end
    if (fl_addr_unstable != 0) begin
      errors++; $display("FAIL %s_fl_addr_stable: %0d changes during read, required 0", tag, fl_addr_unstable);
    end
    if (ram_unstable != 0) begin
      errors++; $display("FAIL %s_ram_stable: %0d changes while ram_we held, required 0", tag, ram_unstable);
    end
    for (int i = 0; i < n && i < wr_addr_log.size() && i < fl_addr_log.size(); i++) begin
      ef = s + FL_AW'(i);
      ea = d + RAM_AW'(i);
      checks += 3;
      if (fl_addr_log[i] !== ef) begin
        errors++; $display("FAIL %s_fl_addr[%0d]: got %06h required %06h", tag, i, fl_addr_log[i], ef);
      end
      if (wr_addr_log[i] !== ea) begin
        errors++; $display("FAIL %s_ram_addr[%0d]: got %05h required %05h", tag, i, wr_addr_log[i], ea);
      end
      if (wr_data_log[i] !== fl_word(ef)) begin
        errors++; $display("FAIL %s_ram_data[%0d]: got %04h required %04h", tag, i, wr_data_log[i], fl_word(ef));
      end
    end
  endtask

  task automatic expect_reset_values(input string tag);
    checks += 9;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy: got %b required 0", tag, busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL %s_done: got %b required 0", tag, done); end
    if (error !== 1'b0) begin errors++; $display("FAIL %s_error: got %b required 0", tag, error); end
    if (bus.ram_we !== 1'b0) begin errors++; $display("FAIL %s_ram_we: got %b required 0", tag, bus.ram_we); end
    if (bus.fl_read_ctrl !== 1'b0) begin
      errors++; $display("FAIL %s_fl_read_ctrl: got %b required 0", tag, bus.fl_read_ctrl);
    end
    if (bus.fl_addr !== '0) begin errors++; $display("FAIL %s_fl_addr: got %06h required 0", tag, bus.fl_addr); end
    if (bus.ram_addr !== '0) begin errors++; $display("FAIL %s_ram_addr: got %05h required 0", tag, bus.ram_addr); end
    if (bus.ram_wdata !== '0) begin
      errors++; $display("FAIL %s_ram_wdata: got %04h required 0", tag, bus.ram_wdata);
    end
    if (words_done !== '0) begin errors++; $display("FAIL %s_words_done: got %0d required 0", tag, words_done); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    expect_reset_values("reset");
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    clear_logs();
    pulse_start(22'h000100, 18'h00200, 16'd4);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start: got %b required 1", busy); end
    wait_idle("basic", 2000);
    verify_copy("basic", 22'h000100, 18'h00200, 4);
  endtask

  task automatic test_timeout();
    int n_wait;
    clear_logs();
    fl_stuck = 1'b1;
    pulse_start(22'h001234, 18'h00040, 16'd3);
    n_wait = 0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (error === 1'b1 || busy !== 1'b1) break;
      n_wait++;
    end
    fl_stuck = 1'b0;
    checks += 6;
    if (error !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b required 1", error); end
    if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b required 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL timeout_done: got %b required 0", done); end
    if (n_wait != TMO) begin
      errors++; $display("FAIL timeout_wait_cycles: got %0d required %0d", n_wait, TMO);
    end
    if (we_cycles_total != 0) begin
      errors++; $display("FAIL timeout_ram_we: asserted %0d cycles, required 0", we_cycles_total);
    end
    if (toggles != 1) begin errors++; $display("FAIL timeout_toggles: got %0d required 1", toggles); end
  endtask

  task automatic test_zero_count();
    clear_logs();
    pulse_start(22'h00AAAA, 18'h01111, 16'd0);
    checks += 3;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b required 1", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b required 0", busy); end
    if (error !== 1'b0) begin errors++; $display("FAIL zero_error: got %b required 0", error); end
    repeat (6) @(posedge clk);
    #1;
    checks += 3;
    if (toggles != 0) begin errors++; $display("FAIL zero_toggles: got %0d required 0", toggles); end
    if (we_cycles_total != 0) begin
      errors++; $display("FAIL zero_ram_we: asserted %0d cycles, required 0", we_cycles_total);
    end
    if (words_done !== 16'd0) begin errors++; $display("FAIL zero_words_done: got %0d required 0", words_done); end
  endtask

  task automatic test_ack_delay();
    clear_logs();
    ack_plan.push_back(1);
    ack_plan.push_back(5);
    ack_plan.push_back(1);
    pulse_start(22'h02F000, 18'h10000, 16'd3);
    wait_idle("ack_delay", 2000);
    verify_copy("ack_delay", 22'h02F000, 18'h10000, 3);
    checks += 2;
    if (wr_cycles_log.size() < 2 || wr_cycles_log[1] != 5) begin
      errors++; $display("FAIL ack_delay_we_hold: word 2 held %0d cycles, required 5",
                         (wr_cycles_log.size() < 2) ? -1 : wr_cycles_log[1]);
    end
    if (wr_cycles_log.size() < 1 || wr_cycles_log[0] != 1) begin
      errors++; $display("FAIL ack_delay_we_immediate: word 1 held %0d cycles, required 1",
                         (wr_cycles_log.size() < 1) ? -1 : wr_cycles_log[0]);
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    pulse_start(22'h3FFFFF, 18'h3FFFF, 16'd2);
    wait_idle("wrap", 2000);
    verify_copy("wrap", 22'h3FFFFF, 18'h3FFFF, 2);
    checks++;
    if (fl_addr_log.size() < 2 || fl_addr_log[1] !== 22'h000000) begin
      errors++; $display("FAIL wrap_second_fl_addr: got %06h required 000000",
                         (fl_addr_log.size() < 2) ? 22'h3FFFFF : fl_addr_log[1]);
    end
  endtask

  task automatic test_restart_and_reset();
    logic [FL_AW-1:0]  s;
    logic [RAM_AW-1:0] d;
    int                k;
    clear_logs();
    s = FL_AW'($urandom());
    d = RAM_AW'($urandom());
    pulse_start(s, d, 16'd8);
    repeat (10) @(posedge clk);
    #1;
    pulse_start(s ^ 22'h155555, d ^ 18'h2AAAA, 16'd3);
    wait_idle("restart", 3000);
    verify_copy("restart", s, d, 8);

    clear_logs();
    pulse_start(s + 22'd64, d + 18'd64, 16'd8);
    k = 0;
    while (wr_addr_log.size() < 2 && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midcopy_busy_before_rst: got %b required 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    expect_reset_values("midcopy_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [FL_AW-1:0]  s;
    logic [RAM_AW-1:0] d;
    int                n;
    for (int it = 0; it < 6; it++) begin
      clear_logs();
      s = FL_AW'($urandom());
      d = RAM_AW'($urandom());
      n = $urandom_range(6, 1);
      for (int w = 0; w < n; w++) ack_plan.push_back($urandom_range(4, 1));
      pulse_start(s, d, 16'(n));
      wait_idle("random", 3000);
      verify_copy("random", s, d, n);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_zero_count();
    test_ack_delay();
    test_wrap();
    test_restart_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
